// File: rtl/mw_add_seq.sv
// Multi-word adder that walks one 16-bit add stage across WORDS words, least significant first.
// Define MW_ADD_SEQ_SUB_EN to add a 'sub' port selecting in1 + ~in2 + cin.
module mw_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in1,
    input  logic [16*WORDS-1:0]   in2,
    input  logic                  cin,
`ifdef MW_ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout
);

    localparam int N  = 16 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_q, b_q, sum_q, b_in;
    logic            carry_q;
    logic [16:0]     add;
    logic            accept;

`ifdef MW_ADD_SEQ_SUB_EN
    assign b_in = sub ? ~in2 : in2;
`else
    assign b_in = in2;
`endif

    // The single shared add stage; operands shift down so word k sits at the bottom in RUN cycle k.
    assign add    = {1'b0, a_q[15:0]} + {1'b0, b_q[15:0]} + {16'b0, carry_q};
    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= in1;
            b_q     <= b_in;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> 16;
            b_q     <= b_q >> 16;
            carry_q <= add[16];
            // New word enters at the top; after WORDS shifts every word is in place.
            sum_q   <= N'({add[15:0], sum_q} >> 16);
            cnt     <= cnt + 1'b1;
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Randomized self-checking bench for mw_add_seq: WORDS=4 main instance plus a WORDS=1 instance.
// The reference is plain wide-integer arithmetic on the captured operands.
module tb_mw_add_seq;

    localparam int W = 4;
    localparam int N = 16 * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [N-1:0] in1 = '0, in2 = '0;
    logic         in_ready, out_valid, cout;
    logic [N-1:0] sum;
    logic         sub_r = 1'b0;

    logic         s_valid = 1'b0, s_oready = 1'b0, s_cin = 1'b0;
    logic [15:0]  s_in1 = '0, s_in2 = '0;
    logic         s_iready, s_ovalid, s_cout;
    logic [15:0]  s_sum;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mw_add_seq #(.WORDS(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .cin(cin),
`ifdef MW_ADD_SEQ_SUB_EN
        .sub(sub_r),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    mw_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_iready),
        .in1(s_in1), .in2(s_in2), .cin(s_cin),
`ifdef MW_ADD_SEQ_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(s_ovalid), .out_ready(s_oready), .sum(s_sum), .cout(s_cout)
    );

    task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c, input logic s);
        logic [N-1:0] bb;
        bb = s ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c};
    endfunction

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, scramble inputs, time the result, hold it, release it.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                      input int hold, input string tag);
        logic [N:0] exp, held;
        int edges;
        int g;
        exp = model(a, b, c, sub_r);
        g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        chk({tag, "_ready"}, {{N{1'b0}}, in_ready}, 1);
        in1 = a; in2 = b; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in1 = rnd64(); in2 = rnd64(); cin = ~c; sub_r = ~sub_r;
        chk({tag, "_busy"}, {{N{1'b0}}, in_ready}, 0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            tick();
            edges++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        sub_r = ~sub_r;
        chk({tag, "_lat"}, (N+1)'(edges), (N+1)'(W));
        chk({tag, "_res"}, {cout, sum}, exp);
        held = {cout, sum};
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {cout, sum}, held);
            chk({tag, "_hvld"}, {{N{1'b0}}, out_valid}, 1);
            chk({tag, "_hrdy"}, {{N{1'b0}}, in_ready}, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_clr"}, {{N{1'b0}}, out_valid}, 0);
        chk({tag, "_rdy"}, {{N{1'b0}}, in_ready}, 1);
    endtask

    initial begin
        logic [N:0]   q[$];
        logic [N:0]   e;
        int           last_acc, accepts, i;

        #12;
        chk("rst_sum", {cout, sum}, 0);
        chk("rst_vld", {{N{1'b0}}, out_valid}, 0);
        chk("rst_rdy", {{N{1'b0}}, in_ready}, 1);
        rst_n = 1'b1;
        tick();

        op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0, "ovf");
        op(64'hDA83_DA83_DA83_DA83, 64'h43AF_43AF_43AF_43AF, 1'b0, 1, "pat0");
        op(64'hDA83_DA83_DA83_DA83, 64'h43AF_43AF_43AF_43AF, 1'b1, 3, "pat1");
        chk("pat_const", model(64'hDA83_DA83_DA83_DA83, 64'h43AF_43AF_43AF_43AF, 1'b1, 1'b0),
            65'h1_1E33_1E33_1E33_1E33);

        // Reset after two RUN edges aborts the operation.
        in1 = rnd64(); in2 = rnd64(); cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_sum", {cout, sum}, 0);
        chk("arst_vld", {{N{1'b0}}, out_valid}, 0);
        chk("arst_rdy", {{N{1'b0}}, in_ready}, 1);
        tick();
        chk("arst_hold", {{N{1'b0}}, out_valid}, 0);
        rst_n = 1'b1;
        tick();
        op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0, "post_rst");

        // Back-to-back with in_valid and out_ready held high.
        last_acc = -1; accepts = 0; i = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        while ((accepts < 5 || q.size() > 0) && i < 80) begin
            if (out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chk("b2b_res", {cout, sum}, e);
            end
            if (in_ready) begin
                if (accepts < 5) begin
                    if (last_acc >= 0) chk("b2b_period", (N+1)'(i - last_acc), 6);
                    last_acc = i;
                    in1 = rnd64(); in2 = rnd64(); cin = 1'($urandom);
                    q.push_back(model(in1, in2, cin, 1'b0));
                    accepts++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            i++;
        end
        in_valid = 1'b0;
        chk("b2b_count", (N+1)'(accepts), 5);
        chk("b2b_drain", (N+1)'(q.size()), 0);
        tick(); tick();
        out_ready = 1'b0;

        // Single-word instance: one RUN cycle.
        s_in1 = 16'hFFFF; s_in2 = 16'hFFFF; s_cin = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_in1 = '0; s_in2 = '0; s_cin = 1'b0;
        chk("w1_busy", {{N{1'b0}}, s_iready}, 0);
        tick();
        chk("w1_vld", {{N{1'b0}}, s_ovalid}, 1);
        chk("w1_res", {{(N-16){1'b0}}, s_cout, s_sum}, 17'h1_FFFF);
        s_oready = 1'b1;
        tick();
        s_oready = 1'b0;
        chk("w1_clr", {{N{1'b0}}, s_ovalid}, 0);

`ifdef MW_ADD_SEQ_SUB_EN
        sub_r = 1'b1;
        op(64'd5, 64'd7, 1'b1, 0, "sub_neg");
        op(64'd7, 64'd5, 1'b1, 0, "sub_pos");
        chk("sub_const", model(64'd5, 64'd7, 1'b1, 1'b1), 65'h0_FFFF_FFFF_FFFF_FFFE);
`endif

        for (int k = 0; k < 30; k++) begin
            logic [N-1:0] a, b;
            a = rnd64(); b = rnd64();
            if (k % 5 == 0) a = '1;
`ifdef MW_ADD_SEQ_SUB_EN
            sub_r = 1'($urandom);
`endif
            op(a, b, 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mw_add_seq.md
MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 16-bit words per operand; legal range 1..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand request.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port in1  input  16*WORDS  first operand.
REQ-007 SHALL have port in2  input  16*WORDS  second operand.
REQ-008 SHALL have port cin  input  1  carry into the least significant word.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  16*WORDS  result.
REQ-012 SHALL have port cout  output  1  carry out of the most significant word.

Function
REQ-013 SHALL compute {cout,sum} = in1 + in2 + cin, modulo 2^(16*WORDS+1), using exactly one 16-bit add stage (a+b+c -> 16-bit sum, carry) reused once per cycle.
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after WORDS RUN cycles; DONE->IDLE on out_ready.
REQ-015 SHALL drive in_ready=1 only in IDLE, combinationally from state.
REQ-016 SHALL capture in1, in2 and cin into internal registers on the accepting edge; input changes after acceptance SHALL have no effect.
REQ-017 SHALL process word k (k=0 least significant) in RUN cycle k, feeding the stored carry of word k-1 (cin for k=0) and registering the new carry.
REQ-018 SHALL assert out_valid exactly WORDS rising edges after the accepting edge, in DONE only.
REQ-019 SHALL hold sum, cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on the edge where out_valid&&out_ready; in_ready rises the following cycle (no same-cycle re-accept).
REQ-021 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-022 WORDS=1 SHALL give a single RUN cycle, latency 1.
REQ-023 sum and cout SHALL show the final result only in DONE; during RUN their values are unspecified to consumers but SHALL be deterministic.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, sum=0, cout=0, out_valid=0, word counter=0, carry register=0; in_ready=1.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; first request after release SHALL complete correctly.

Configuration
REQ-026 Macro MW_ADD_SEQ_SUB_EN defined: SHALL add port sub (input, 1), captured with operands; sub=1 computes in1 + ~in2 + cin (cin=1 gives in1-in2, cout=1 means no borrow).
REQ-027 Macro MW_ADD_SEQ_SUB_EN undefined: SHALL have no sub port and perform addition only; all other behaviour identical.

Verification (WORDS=4 unless stated)
REQ-028 in1=FFFF_FFFF_FFFF_FFFF, in2=0000_0000_0000_0001, cin=0, out_ready=1 -> out_valid 4 edges after accept, sum=0, cout=1.
REQ-029 in1=DA83_DA83_DA83_DA83, in2=43AF_43AF_43AF_43AF, cin=0 -> sum=1E33_1E33_1E33_1E32, cout=1; with cin=1 -> sum=1E33_1E33_1E33_1E33, cout=1.
REQ-030 out_ready=0 for 3 cycles in DONE -> out_valid, sum, cout stable, in_ready=0; out_ready=1 -> out_valid=0 next edge, in_ready=1.
REQ-031 rst_n pulsed low after 2 RUN cycles -> sum=0, cout=0, out_valid=0, in_ready=1 immediately; next op AAAA_AAAA_AAAA_AAAA+5555_5555_5555_5555, cin=1 -> sum=0, cout=1.
REQ-032 in_valid held high, out_ready=1 -> one acceptance per 6 cycles (accept, 4 RUN edges, DONE), each result correct; WORDS=1 rerun with FFFF+FFFF, cin=1 -> sum=FFFF, cout=1.
REQ-033 With MW_ADD_SEQ_SUB_EN: in1=5, in2=7, sub=1, cin=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0; in1=7, in2=5 -> sum=2, cout=1.
